// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller: source indices, register
// addresses, the default vector base, the IME state encoding and a helper that
// turns a source index into its RST vector.
// -----------------------------------------------------------------------------
package intc_pkg;

    // Interrupt source indices (bit positions in IF / IE)
    localparam int INT_VBLANK = 0;
    localparam int INT_STAT   = 1;
    localparam int INT_TIMER  = 2;
    localparam int INT_SERIAL = 3;
    localparam int INT_JOYPAD = 4;

    // Memory-mapped register addresses (decoded outside this block)
    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    // Vector of source 0; source n lives 8 bytes further on
    localparam logic [7:0] VEC_BASE = 8'h40;

    // Interrupt master enable states
    typedef enum logic [1:0] {
        IME_OFF   = 2'd0,
        IME_ARMED = 2'd1,
        IME_ON    = 2'd2
    } ime_state_e;

    // RST vector for a source index: base + 8*idx
    function automatic logic [7:0] vector_for(input logic [7:0] base,
                                              input logic [2:0] idx);
        return base + {2'b00, idx, 3'b000};
    endfunction

endpackage

// File: rtl/intc_priority_enc.sv
// -----------------------------------------------------------------------------
// intc_priority_enc
// Combinational lowest-set-bit encoder. Bit 0 has the highest priority.
//
// Ports:
//   i_Req    [N-1:0]  request vector
//   o_Valid           at least one bit of i_Req is set
//   o_Idx    [2:0]    index of the lowest set bit (0 when none set)
// -----------------------------------------------------------------------------
module intc_priority_enc #(
    parameter int N = 5
) (
    input  logic [N-1:0] i_Req,
    output logic         o_Valid,
    output logic [2:0]   o_Idx
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        o_Valid = 1'b0;
        o_Idx   = 3'd0;
        // Scan from the top down so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_Req[i]) begin
                o_Valid = 1'b1;
                o_Idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Holds IF (0xFF0F), IE (0xFFFF) and the IME master enable, latches the five
// interrupt sources, resolves priority, requests dispatch at instruction
// boundaries and supplies the RST vector on acknowledge.
//
// Optional feature (macro INTC_HALT_BUG_EN): adds i_Halt / o_Halt_Bug, a
// one-cycle pulse when HALT executes with IME not ON and an interrupt pending.
//
// Ports:
//   i_Clk, i_nRst         clock (rising edge), async active-low reset
//   i_Enable              clock enable; all state holds when low
//   i_Request  [NUM_SRC]  one-cycle source event pulses
//   i_Sel_IF / i_Sel_IE   register select (IF wins if both)
//   i_Write, i_Data       write strobe and data
//   o_Data                read data (8'h00 when nothing selected)
//   i_Instr_Boundary      last cycle of each instruction
//   i_EI, i_DI, i_RETI    decoded instructions
//   i_Ack                 dispatch acknowledge from the control unit
//   o_Irq                 registered dispatch request
//   o_Vector              vector latched on acknowledge
//   o_Pending  [NUM_SRC]  IE & IF, independent of IME
//   o_IME                 1 when IME is ON
//   i_Halt, o_Halt_Bug    only with INTC_HALT_BUG_EN
// -----------------------------------------------------------------------------
module interrupt_controller #(
    parameter int         NUM_SRC  = 5,
    parameter logic [7:0] VEC_BASE = intc_pkg::VEC_BASE
) (
    input  logic               i_Clk,
    input  logic               i_nRst,
    input  logic               i_Enable,
`ifdef INTC_HALT_BUG_EN
    input  logic               i_Halt,
    output logic               o_Halt_Bug,
`endif
    input  logic [NUM_SRC-1:0] i_Request,
    input  logic               i_Sel_IF,
    input  logic               i_Sel_IE,
    input  logic               i_Write,
    input  logic [7:0]         i_Data,
    output logic [7:0]         o_Data,
    input  logic               i_Instr_Boundary,
    input  logic               i_EI,
    input  logic               i_DI,
    input  logic               i_RETI,
    input  logic               i_Ack,
    output logic               o_Irq,
    output logic [7:0]         o_Vector,
    output logic [NUM_SRC-1:0] o_Pending,
    output logic               o_IME
);

    import intc_pkg::*;

    // ---------------------------------------------------------------- state
    logic [NUM_SRC-1:0] if_q,     if_d;
    logic [7:0]         ie_q,     ie_d;
    ime_state_e         ime_q,    ime_d;
    logic               skip_q,   skip_d;   // EI's own boundary not yet seen
    logic               irq_q,    irq_d;
    logic [7:0]         vector_q, vector_d;

    logic               ack_take;
    logic               enc_valid;
    logic [2:0]         enc_idx;

    assign o_Pending = ie_q[NUM_SRC-1:0] & if_q;
    assign o_Irq     = irq_q;
    assign o_Vector  = vector_q;
    assign o_IME     = (ime_q == IME_ON);

    // An acknowledge only means something while a request is outstanding.
    assign ack_take  = i_Ack & irq_q;

    // Priority is resolved on the live pending set, so a change to IE/IF
    // between request and acknowledge is honoured.
    intc_priority_enc #(
        .N (NUM_SRC)
    ) u_prio (
        .i_Req   (o_Pending),
        .o_Valid (enc_valid),
        .o_Idx   (enc_idx)
    );

    // ------------------------------------------------------------ read mux
    always_comb begin
        o_Data = 8'h00;
        if (i_Sel_IF) begin
            o_Data = {{(8 - NUM_SRC){1'b1}}, if_q};
        end else if (i_Sel_IE) begin
            o_Data = ie_q;
        end
    end

    // --------------------------------------------------- IF / IE / vector
    always_comb begin
        if_d     = if_q;
        ie_d     = ie_q;
        vector_d = vector_q;

        if (i_Write && i_Sel_IF) begin
            if_d = i_Data[NUM_SRC-1:0];
        end else if (i_Write && i_Sel_IE) begin
            ie_d = i_Data;
        end

        if (ack_take) begin
            if (enc_valid) begin
                if_d[enc_idx] = 1'b0;
                vector_d      = vector_for(VEC_BASE, enc_idx);
            end else begin
                vector_d      = 8'h00;
            end
        end

        // Source events are applied last so they beat a write or ack-clear.
        if_d = if_d | i_Request;
    end

    // --------------------------------------------------------- IME machine
    always_comb begin
        ime_d  = ime_q;
        skip_d = skip_q;
        unique case (ime_q)
            IME_OFF: begin
                if (i_DI) begin
                    ime_d = IME_OFF;
                end else if (i_RETI) begin
                    ime_d = IME_ON;
                end else if (i_EI) begin
                    ime_d  = IME_ARMED;
                    // A boundary in the EI cycle itself is EI's own boundary.
                    skip_d = ~i_Instr_Boundary;
                end
            end
            IME_ARMED: begin
                if (i_DI) begin
                    ime_d = IME_OFF;
                end else if (i_Instr_Boundary) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        ime_d = IME_ON;
                    end
                end
            end
            IME_ON: begin
                if (i_DI || ack_take) begin
                    ime_d = IME_OFF;
                end
            end
            default: ime_d = IME_OFF;
        endcase
    end

    // ------------------------------------------------------- dispatch req
    always_comb begin
        irq_d = irq_q;
        if (ack_take || i_DI) begin
            irq_d = 1'b0;
        end else if (i_Instr_Boundary && (ime_q == IME_ON) && (|o_Pending)) begin
            irq_d = 1'b1;
        end
    end

    // ------------------------------------------------------------ registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            if_q     <= '0;
            ie_q     <= 8'h00;
            ime_q    <= IME_OFF;
            skip_q   <= 1'b0;
            irq_q    <= 1'b0;
            vector_q <= 8'h00;
        end else if (i_Enable) begin
            if_q     <= if_d;
            ie_q     <= ie_d;
            ime_q    <= ime_d;
            skip_q   <= skip_d;
            irq_q    <= irq_d;
            vector_q <= vector_d;
        end
    end

`ifdef INTC_HALT_BUG_EN
    // HALT with IME not ON and something pending: the control unit must skip
    // the PC increment of the next fetch.
    logic halt_bug_q;
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            halt_bug_q <= 1'b0;
        end else if (i_Enable) begin
            halt_bug_q <= i_Halt && (ime_q != IME_ON) && (|o_Pending);
        end
    end
    assign o_Halt_Bug = halt_bug_q;
`endif

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
// Directed scenarios plus a randomized run, all compared against a
// behavioural model of IF/IE/IME/dispatch kept in the bench.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic       i_Clk = 1'b0;
    logic       i_nRst;
    logic       i_Enable;
    logic [4:0] i_Request;
    logic       i_Sel_IF, i_Sel_IE, i_Write;
    logic [7:0] i_Data;
    logic [7:0] o_Data;
    logic       i_Instr_Boundary, i_EI, i_DI, i_RETI, i_Ack;
    logic       o_Irq;
    logic [7:0] o_Vector;
    logic [4:0] o_Pending;
    logic       o_IME;
`ifdef INTC_HALT_BUG_EN
    logic       i_Halt;
    logic       o_Halt_Bug;
`endif

    int checks   = 0;
    int failures = 0;

    // ------------------------------------------------------------- model
    bit [4:0] m_if;
    bit [7:0] m_ie;
    bit       m_on;      // IME currently enabled
    int       m_arm;     // boundaries still to pass before IME turns on (0 = not armed)
    bit       m_irq;
    bit [7:0] m_vec;
`ifdef INTC_HALT_BUG_EN
    bit       m_hb;
`endif

    interrupt_controller dut (
        .i_Clk            (i_Clk),
        .i_nRst           (i_nRst),
        .i_Enable         (i_Enable),
`ifdef INTC_HALT_BUG_EN
        .i_Halt           (i_Halt),
        .o_Halt_Bug       (o_Halt_Bug),
`endif
        .i_Request        (i_Request),
        .i_Sel_IF         (i_Sel_IF),
        .i_Sel_IE         (i_Sel_IE),
        .i_Write          (i_Write),
        .i_Data           (i_Data),
        .o_Data           (o_Data),
        .i_Instr_Boundary (i_Instr_Boundary),
        .i_EI             (i_EI),
        .i_DI             (i_DI),
        .i_RETI           (i_RETI),
        .i_Ack            (i_Ack),
        .o_Irq            (o_Irq),
        .o_Vector         (o_Vector),
        .o_Pending        (o_Pending),
        .o_IME            (o_IME)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic int lowest_set(input bit [4:0] p);
        for (int i = 0; i < 5; i++) if (p[i]) return i;
        return -1;
    endfunction

    function automatic bit [7:0] exp_read(input bit sel_if, input bit sel_ie);
        if (sel_if) return {3'b111, m_if};
        if (sel_ie) return m_ie;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_if = 0; m_ie = 0; m_on = 0; m_arm = 0; m_irq = 0; m_vec = 0;
`ifdef INTC_HALT_BUG_EN
        m_hb = 0;
`endif
    endtask

    // Advance the model by one enabled clock, using the inputs as driven.
    task automatic model_step();
        bit [4:0] pend;
        bit [4:0] nif;
        bit       ack_eff;
        int       n;
        if (!i_Enable) return;
        pend    = m_ie[4:0] & m_if;
        ack_eff = i_Ack && m_irq;
        n       = lowest_set(pend);
        nif     = m_if;
        if (i_Write && i_Sel_IF) nif = i_Data[4:0];
        else if (i_Write && i_Sel_IE) m_ie = i_Data;
        if (ack_eff) begin
            if (n >= 0) begin
                nif[n] = 1'b0;
                m_vec  = 8'(64 + 8 * n);
            end else begin
                m_vec  = 8'h00;
            end
        end
        nif = nif | i_Request;
`ifdef INTC_HALT_BUG_EN
        m_hb = i_Halt && !m_on && (pend != 0);
`endif
        if (ack_eff || i_DI) m_irq = 1'b0;
        else if (i_Instr_Boundary && m_on && pend != 0) m_irq = 1'b1;
        if (i_DI) begin
            m_on = 0; m_arm = 0;
        end else if (m_on) begin
            if (ack_eff) m_on = 0;
        end else if (m_arm > 0) begin
            if (i_Instr_Boundary) begin
                m_arm--;
                if (m_arm == 0) m_on = 1;
            end
        end else if (i_RETI) begin
            m_on = 1;
        end else if (i_EI) begin
            m_arm = i_Instr_Boundary ? 1 : 2;
        end
        m_if = nif;
    endtask

    task automatic idle_inputs();
        i_Request = 0; i_Sel_IF = 0; i_Sel_IE = 0; i_Write = 0; i_Data = 0;
        i_Instr_Boundary = 0; i_EI = 0; i_DI = 0; i_RETI = 0; i_Ack = 0;
`ifdef INTC_HALT_BUG_EN
        i_Halt = 0;
`endif
    endtask

    // One clock: inputs already driven; outputs settle 1 time unit later.
    task automatic tick();
        @(posedge i_Clk);
        model_step();
        #1;
        idle_inputs();
    endtask

    task automatic wr(input bit sel_if, input bit sel_ie, input bit [7:0] d);
        i_Sel_IF = sel_if; i_Sel_IE = sel_ie; i_Write = 1; i_Data = d;
        tick();
    endtask

    task automatic rd(input bit sel_if, input bit sel_ie, output bit [7:0] d);
        i_Sel_IF = sel_if; i_Sel_IE = sel_ie;
        #1;
        d = o_Data;
        i_Sel_IF = 0; i_Sel_IE = 0;
    endtask

    // ------------------------------------------------------------- tests
    task automatic test_reset();
        bit [7:0] d;
        i_nRst = 0; i_Enable = 1; idle_inputs(); model_reset();
        #12;
        checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%0h exp=0", o_Irq); end
        checks++; if (o_Vector !== 8'h00) begin failures++; $display("FAIL rst_vec got=%0h exp=00", o_Vector); end
        checks++; if (o_Pending !== 5'h00) begin failures++; $display("FAIL rst_pend got=%0h exp=00", o_Pending); end
        checks++; if (o_IME !== 1'b0) begin failures++; $display("FAIL rst_ime got=%0h exp=0", o_IME); end
        checks++; if (o_Data !== 8'h00) begin failures++; $display("FAIL rst_nosel got=%0h exp=00", o_Data); end
        rd(1, 0, d);
        checks++; if (d !== 8'hE0) begin failures++; $display("FAIL rst_if got=%0h exp=e0", d); end
        @(negedge i_Clk);
        i_nRst = 1;
    endtask

    task automatic test_basic_dispatch();
        bit [7:0] d;
        i_RETI = 1; tick();
        wr(0, 1, 8'h05);
        i_Request = 5'b00101; tick();
        i_Instr_Boundary = 1; tick();
        checks++; if (o_Irq !== 1'b1) begin failures++; $display("FAIL basic_irq got=%0h exp=1", o_Irq); end
        i_Ack = 1; tick();
        checks++; if (o_Vector !== 8'h40) begin failures++; $display("FAIL basic_vec got=%0h exp=40", o_Vector); end
        rd(1, 0, d);
        checks++; if (d !== 8'hE4) begin failures++; $display("FAIL basic_if got=%0h exp=e4", d); end
        checks++; if (o_IME !== 1'b0) begin failures++; $display("FAIL basic_ime got=%0h exp=0", o_IME); end
        checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL basic_irqclr got=%0h exp=0", o_Irq); end
    endtask

    task automatic test_ei_delay();
        i_DI = 1; tick();
        wr(0, 1, 8'h1F);
        wr(1, 0, 8'h04);
        i_EI = 1; tick();
        i_Instr_Boundary = 1; tick();
        checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL ei_b1_irq got=%0h exp=0", o_Irq); end
        checks++; if (o_IME !== 1'b0) begin failures++; $display("FAIL ei_b1_ime got=%0h exp=0", o_IME); end
        i_Instr_Boundary = 1; tick();
        checks++; if (o_IME !== 1'b1) begin failures++; $display("FAIL ei_b2_ime got=%0h exp=1", o_IME); end
        checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL ei_b2_irq got=%0h exp=0", o_Irq); end
        i_Instr_Boundary = 1; tick();
        checks++; if (o_Irq !== 1'b1) begin failures++; $display("FAIL ei_b3_irq got=%0h exp=1", o_Irq); end
        i_Ack = 1; tick();
        checks++; if (o_Vector !== 8'h50) begin failures++; $display("FAIL ei_vec got=%0h exp=50", o_Vector); end
    endtask

    task automatic test_ei_cancel();
        wr(1, 0, 8'h01);
        wr(0, 1, 8'h01);
        i_EI = 1; tick();
        i_DI = 1; tick();
        for (int k = 0; k < 3; k++) begin
            i_Instr_Boundary = 1; tick();
            checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL cancel_irq%0d got=%0h exp=0", k, o_Irq); end
            checks++; if (o_IME !== 1'b0) begin failures++; $display("FAIL cancel_ime%0d got=%0h exp=0", k, o_IME); end
        end
    endtask

    task automatic test_ack_nothing_pending();
        bit [7:0] d;
        i_RETI = 1; tick();
        i_Instr_Boundary = 1; tick();
        checks++; if (o_Irq !== 1'b1) begin failures++; $display("FAIL empty_irq got=%0h exp=1", o_Irq); end
        wr(0, 1, 8'h00);
        i_Ack = 1; tick();
        checks++; if (o_Vector !== 8'h00) begin failures++; $display("FAIL empty_vec got=%0h exp=00", o_Vector); end
        rd(1, 0, d);
        checks++; if (d !== 8'hE1) begin failures++; $display("FAIL empty_if got=%0h exp=e1", d); end
        checks++; if (o_IME !== 1'b0) begin failures++; $display("FAIL empty_ime got=%0h exp=0", o_IME); end
    endtask

    task automatic test_set_beats_write();
        bit [7:0] d;
        i_Request = 5'b00010; wr(1, 0, 8'h00);
        rd(1, 0, d);
        checks++; if (d !== 8'hE2) begin failures++; $display("FAIL setwin_if got=%0h exp=e2", d); end
        checks++; if (o_Pending !== 5'h00) begin failures++; $display("FAIL setwin_pend0 got=%0h exp=00", o_Pending); end
        wr(0, 1, 8'h02);
        checks++; if (o_Pending !== 5'h02) begin failures++; $display("FAIL setwin_pend got=%0h exp=02", o_Pending); end
        checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL setwin_irq got=%0h exp=0", o_Irq); end
    endtask

    task automatic test_reset_mid_dispatch();
        bit [7:0] d;
        i_RETI = 1; tick();
        i_Instr_Boundary = 1; tick();
        i_Ack = 1; tick();
        checks++; if (o_Vector !== 8'h48) begin failures++; $display("FAIL mid_vec48 got=%0h exp=48", o_Vector); end
        i_Request = 5'b00010; i_RETI = 1; tick();
        i_Instr_Boundary = 1; tick();
        checks++; if (o_Irq !== 1'b1) begin failures++; $display("FAIL mid_irq got=%0h exp=1", o_Irq); end
        #2;
        i_nRst = 0;
        model_reset();
        #1;
        checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq got=%0h exp=0", o_Irq); end
        checks++; if (o_IME !== 1'b0) begin failures++; $display("FAIL mid_rst_ime got=%0h exp=0", o_IME); end
        checks++; if (o_Vector !== 8'h00) begin failures++; $display("FAIL mid_rst_vec got=%0h exp=00", o_Vector); end
        rd(1, 0, d);
        checks++; if (d !== 8'hE0) begin failures++; $display("FAIL mid_rst_if got=%0h exp=e0", d); end
        rd(0, 1, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL mid_rst_ie got=%0h exp=00", d); end
        @(negedge i_Clk);
        i_nRst = 1;
        wr(0, 1, 8'h01);
        i_Request = 5'b00001; i_RETI = 1; tick();
        i_Instr_Boundary = 1; tick();
        checks++; if (o_Irq !== 1'b1) begin failures++; $display("FAIL fresh_irq got=%0h exp=1", o_Irq); end
        i_Ack = 1; tick();
        checks++; if (o_Vector !== 8'h40) begin failures++; $display("FAIL fresh_vec got=%0h exp=40", o_Vector); end
        checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL fresh_irqclr got=%0h exp=0", o_Irq); end
    endtask

    task automatic test_random();
        int k;
        bit [7:0] exp_d;
        for (int c = 0; c < 600; c++) begin
            i_Enable         = ($urandom_range(0, 9) != 0);
            i_Request        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
            k                = $urandom_range(0, 9);
            i_Sel_IF         = (k == 0 || k == 2 || k == 5);
            i_Sel_IE         = (k == 1 || k == 2 || k == 6);
            i_Write          = (k <= 2);
            i_Data           = 8'($urandom);
            i_Instr_Boundary = ($urandom_range(0, 2) == 0);
            i_EI             = ($urandom_range(0, 9) == 0);
            i_DI             = ($urandom_range(0, 14) == 0);
            i_RETI           = ($urandom_range(0, 14) == 0);
            i_Ack            = ($urandom_range(0, 3) == 0);
`ifdef INTC_HALT_BUG_EN
            i_Halt           = ($urandom_range(0, 5) == 0);
`endif
            #1;
            exp_d = exp_read(i_Sel_IF, i_Sel_IE);
            checks++; if (o_Data !== exp_d) begin failures++; $display("FAIL rnd_data c=%0d got=%0h exp=%0h", c, o_Data, exp_d); end
            tick();
            checks++; if (o_Irq !== m_irq) begin failures++; $display("FAIL rnd_irq c=%0d got=%0h exp=%0h", c, o_Irq, m_irq); end
            checks++; if (o_Vector !== m_vec) begin failures++; $display("FAIL rnd_vec c=%0d got=%0h exp=%0h", c, o_Vector, m_vec); end
            checks++; if (o_Pending !== (m_ie[4:0] & m_if)) begin failures++; $display("FAIL rnd_pend c=%0d got=%0h exp=%0h", c, o_Pending, m_ie[4:0] & m_if); end
            checks++; if (o_IME !== m_on) begin failures++; $display("FAIL rnd_ime c=%0d got=%0h exp=%0h", c, o_IME, m_on); end
`ifdef INTC_HALT_BUG_EN
            checks++; if (o_Halt_Bug !== m_hb) begin failures++; $display("FAIL rnd_hb c=%0d got=%0h exp=%0h", c, o_Halt_Bug, m_hb); end
`endif
        end
        i_Enable = 1;
    endtask

    initial begin
        test_reset();
        test_basic_dispatch();
        test_ei_delay();
        test_ei_cancel();
        test_ack_nothing_pending();
        test_set_beats_write();
        test_reset_mid_dispatch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Holds the IF (0xFF0F) and IE (0xFFFF) registers and the IME master enable.
- Latches the five interrupt sources and resolves priority.
- Requests dispatch from the control unit at instruction boundaries and supplies the RST vector.
- Its o_Pending output drives the control unit's i_Interrupts for HALT wake.

Parameters:
- NUM_SRC, 5, number of interrupt sources (bit 0 = VBlank, 1 = STAT, 2 = Timer, 3 = Serial, 4 = Joypad).
- VEC_BASE, 8'h40, vector of source 0; source n vectors to VEC_BASE + 8*n.

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_nRst  in  1  asynchronous active-low reset.
- i_Enable  in  1  clock enable; all state holds when low.
- i_Request  in  NUM_SRC  one-cycle source event pulses.
- i_Sel_IF  in  1  register access targets IF.
- i_Sel_IE  in  1  register access targets IE.
- i_Write  in  1  write strobe for the selected register.
- i_Data  in  8  write data.
- o_Data  out  8  read data for the selected register; 8'h00 when nothing is selected.
- i_Instr_Boundary  in  1  pulse on the last cycle of each instruction.
- i_EI  in  1  EI decoded.
- i_DI  in  1  DI decoded.
- i_RETI  in  1  RETI decoded.
- i_Ack  in  1  control unit dispatch acknowledge, one-cycle pulse.
- o_Irq  out  1  dispatch request.
- o_Vector  out  8  latched dispatch vector.
- o_Pending  out  NUM_SRC  IE & IF, independent of IME.
- o_IME  out  1  current IME.

Behaviour:
- Reset: IF=5'h00, IE=8'h00, IME state OFF, vector=8'h00. All outputs are 0.
- IF set: bit n is set on the cycle i_Request[n] is high. A set in the same cycle as a CPU write or ack-clear of that bit wins.
- IF write: bits [4:0] take i_Data[4:0]. IF read returns {3'b111, IF}.
- IE: full 8-bit read/write. Only bits [4:0] gate interrupts.
- If i_Sel_IF and i_Sel_IE are both high, IF takes priority.
- IME state machine (OFF, ARMED, ON):
  - OFF: i_EI goes to ARMED. i_RETI goes to ON.
  - ARMED: the EI instruction's own boundary is ignored. At the next i_Instr_Boundary, go to ON. i_DI goes to OFF.
  - ON: i_DI goes to OFF. i_Ack goes to OFF.
  - i_DI cancels ARMED immediately.
  - i_DI and i_EI in the same cycle: DI wins.
- o_IME is 1 only in ON.
- o_Irq is registered. It sets on an i_Instr_Boundary cycle when the state is ON and |o_Pending. It clears on i_Ack, i_DI, or reset.
  - It is never asserted in ARMED, so dispatch occurs at the earliest after the instruction following EI.
- Ack (only when o_Irq is high; otherwise ignored):
  - Priority encoder selects the lowest-index set bit of the current o_Pending, not the value latched at request time.
  - That IF bit is cleared.
  - o_Vector = VEC_BASE + 8*n, registered, valid from the cycle after i_Ack.
  - If o_Pending became 0 between request and ack (e.g. IE rewritten), o_Vector = 8'h00, no IF bit is cleared, and IME is still cleared.
- o_Pending is combinational from the registers. The control unit wakes from HALT on |o_Pending regardless of IME.
- Reset mid-dispatch returns everything to reset values. The next request starts a fresh handshake.

Optional Feature:
- Macro INTC_HALT_BUG_EN.
- Defined:
  - Adds input i_Halt (HALT decoded) and output o_Halt_Bug.
  - o_Halt_Bug is a one-cycle registered pulse when i_Halt is seen with IME state not ON and |o_Pending.
  - The control unit uses it to skip the PC increment of the next fetch.
- Undefined: neither port exists and there is no logic.

Decomposition:
- Package intc_pkg holds:
  - source index constants (INT_VBLANK=0 … INT_JOYPAD=4);
  - register address constants 16'hFF0F and 16'hFFFF;
  - VEC_BASE;
  - IME state enum {IME_OFF, IME_ARMED, IME_ON}.
- One sub-module: intc_priority_enc, a combinational lowest-set-bit encoder producing valid plus the 3-bit index.

Test Plan:
- Write IE=8'h05, then pulse i_Request[2] and i_Request[0] in the same cycle while ON, then boundary -> o_Irq=1. After i_Ack: o_Vector=8'h40, IF reads 8'hE4, o_IME=0.
- IE=8'h1F, IF=8'h04, state OFF; pulse i_EI, then boundary (EI end) -> o_Irq=0. Second boundary -> IME=ON, o_Irq still 0. Third boundary -> o_Irq=1, ack gives 8'h50.
- i_EI then i_DI before the next boundary -> state OFF; no o_Irq across 3 boundaries even with IF=IE=8'h01.
- o_Irq pending, write IE=8'h00, then i_Ack -> o_Vector=8'h00, IF unchanged, o_IME=0.
- i_Request[1] in the same cycle as an IF write of 8'h00 -> IF reads 8'hE2. With IE=8'h00 and IME OFF, o_Pending=0. After IE=8'h02, o_Pending=5'h02 with o_Irq=0.
- Assert i_nRst=0 while o_Irq=1 -> o_Irq, o_IME, o_Vector=0 and IF/IE read 8'hE0/8'h00 in the same cycle, before any clock edge.
